// File: rtl/hazard_forward_unit_if.sv
// Signal bundle between the pipeline registers and the hazard/forwarding unit.
// The master side is the pipeline control and the slave side is the unit itself.
interface hazard_forward_unit_if #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int CNT_W   = 16
);
   logic [NUM_SRC*REG_AW-1:0] IDEX_RS;
   logic [REG_AW-1:0]         EM_RD;
   logic                      EM_RegWrite;
   logic [REG_AW-1:0]         MW_RD;
   logic                      MW_RegWrite;
   logic                      IDEX_MemRead;
   logic [REG_AW-1:0]         IDEX_RD;
   logic [NUM_SRC*REG_AW-1:0] IFID_RS;
   logic [NUM_SRC-1:0]        IFID_RS_Used;
   logic                      flush;
   logic [2*NUM_SRC-1:0]      Forward;
   logic                      stall;
   logic                      bubble;
   logic [CNT_W-1:0]          stall_count;

   modport master (
      output IDEX_RS, EM_RD, EM_RegWrite, MW_RD, MW_RegWrite,
             IDEX_MemRead, IDEX_RD, IFID_RS, IFID_RS_Used, flush,
      input  Forward, stall, bubble, stall_count
   );

   modport slave (
      input  IDEX_RS, EM_RD, EM_RegWrite, MW_RD, MW_RegWrite,
             IDEX_MemRead, IDEX_RD, IFID_RS, IFID_RS_Used, flush,
      output Forward, stall, bubble, stall_count
   );
endinterface

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding plus load-use stall control for a NUM_SRC-operand pipeline.
// A load-use hazard holds PC/IF-ID and bubbles ID/EX for LOAD_STALL cycles unless a flush kills it.
module hazard_forward_unit #(
   parameter int REG_AW     = 5,
   parameter int NUM_SRC    = 2,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_forward_unit_if.slave bus
);

   typedef enum logic {
      IDLE,
      STALL
   } state_t;

   localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL - 1);
   localparam bit         MULTI_CYCLE  = (LOAD_STALL > 1);

   state_t               state_q;
   state_t               state_d;
   logic [3:0]           cnt_q;
   logic [3:0]           cnt_d;
   logic [2*NUM_SRC-1:0] forward;
   logic [NUM_SRC-1:0]   src_hit;
   logic                 hz;
   logic                 stall_int;
   logic [CNT_W-1:0]     stall_count_q;

   // EX/MEM is the younger result, so it is tested first; register 0 is hard-wired and never forwarded.
   always_comb begin
      forward = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.EM_RegWrite && (bus.EM_RD != '0) &&
             (bus.EM_RD == bus.IDEX_RS[i*REG_AW +: REG_AW])) begin
            forward[2*i +: 2] = 2'b10;
         end else if (bus.MW_RegWrite && (bus.MW_RD != '0) &&
                      (bus.MW_RD == bus.IDEX_RS[i*REG_AW +: REG_AW])) begin
            forward[2*i +: 2] = 2'b01;
         end
      end
   end

   always_comb begin
      src_hit = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_hit[i] = bus.IFID_RS_Used[i] &&
                      (bus.IFID_RS[i*REG_AW +: REG_AW] == bus.IDEX_RD);
      end
   end

   assign hz = bus.IDEX_MemRead && (bus.IDEX_RD != '0) && (|src_hit);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // While in STALL the held IF/ID is not re-checked; it is looked at again once back in IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hz && MULTI_CYCLE) begin
                  state_d = STALL;
                  cnt_d   = STALL_RELOAD;
               end
            end
            STALL: begin
               if (cnt_q <= 4'd1) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      stall_int = 1'b0;
      if (!reset && !bus.flush) begin
         case (state_q)
            IDLE:    stall_int = hz;
            STALL:   stall_int = 1'b1;
            default: stall_int = 1'b0;
         endcase
      end
   end

   // Saturating so a long run of stalls never wraps back to a small, misleading value.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_q <= '0;
      end else if (stall_int && (stall_count_q != '1)) begin
         stall_count_q <= stall_count_q + 1'b1;
      end
   end

   assign bus.Forward     = forward;
   assign bus.stall       = stall_int;
   assign bus.bubble      = stall_int;
   assign bus.stall_count = stall_count_q;

endmodule
